// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
// Arbiter state encodings, reset level and default bus widths.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUSY_M0 = 2'd1,
        ARB_BUSY_M1 = 2'd2
    } arb_state_t;

    localparam logic        RstEnable  = 1'b1;
    localparam logic [31:0] ZeroWord   = 32'h0000_0000;
    localparam int          DEFAULT_AW = 32;
    localparam int          DEFAULT_DW = 32;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the data port (m0), fetch port (m1), arbiter and memory slave.
// The master modport is the arbiter's view; slave is the surrounding environment's view.
interface mem_bus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_ack;
    logic [DW-1:0] m0_rdata;
    logic          m0_err;

    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_ack;
    logic [DW-1:0] m1_rdata;
    logic          m1_err;

    logic          s_req;
    logic          s_we;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic          s_ack;
    logic [DW-1:0] s_rdata;

    logic          hold_flag;

    modport master (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_ack, m0_rdata, m0_err,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_ack, m1_rdata, m1_err,
        output s_req, s_we, s_addr, s_wdata,
        input  s_ack, s_rdata,
        output hold_flag
    );

    modport slave (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_ack, m0_rdata, m0_err,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_ack, m1_rdata, m1_err,
        input  s_req, s_we, s_addr, s_wdata,
        output s_ack, s_rdata,
        input  hold_flag
    );
endinterface

// File: rtl/mem_bus_arbiter_watchdog.sv
// Bus watchdog: counts enabled cycles and pulses expire on the TIMEOUT-th one.
module arb_watchdog
    import mem_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [WW-1:0] count;

    assign expire = enable && (count == WW'(TIMEOUT - 1));

    // clear has priority so the count never wraps past TIMEOUT-1
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// Fixed-priority arbiter sharing one memory slave between data (m0) and fetch (m1) ports.
// Define ARB_STARVE_GUARD_EN to force an m1 grant after MAX_CONSEC back-to-back m0 grants.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int AW         = DEFAULT_AW,
    parameter int DW         = DEFAULT_DW,
    parameter int TIMEOUT    = 16,
    parameter int MAX_CONSEC = 4
) (
    input  logic               clk,
    input  logic               rst,
    mem_bus_arbiter_if.master  bus
);
    if (TIMEOUT < 2 || MAX_CONSEC < 1) begin : g_param_check
        $error("mem_bus_arbiter: TIMEOUT must be >= 2 and MAX_CONSEC >= 1");
    end

    arb_state_t state;
    logic       wd_clear;
    logic       wd_enable;
    logic       wd_expire;
    logic       starve;
    logic       grant_m0;
    logic       grant_m1;

    assign wd_enable = (state != ARB_IDLE);
    assign wd_clear  = (state == ARB_IDLE) || bus.s_ack || wd_expire;

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expire (wd_expire)
    );

`ifdef ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(MAX_CONSEC + 1);

    logic [CW-1:0] consec;

    assign starve = bus.m1_req && (consec == CW'(MAX_CONSEC));

    // counts m0 grants that left m1 waiting; any m1 grant or uncontended m0 grant resets it
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            consec <= '0;
        end else if (state == ARB_IDLE) begin
            if (grant_m0) begin
                consec <= bus.m1_req ? consec + 1'b1 : '0;
            end else if (grant_m1) begin
                consec <= '0;
            end
        end
    end
`else
    assign starve = 1'b0;
`endif

    assign grant_m0 = bus.m0_req && !starve;
    assign grant_m1 = bus.m1_req && !grant_m0;

    // fetch stays stalled until the cycle its own transfer completes
    assign bus.hold_flag = bus.m1_req & ~((state == ARB_BUSY_M1) & bus.s_ack);

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state        <= ARB_IDLE;
            bus.s_req    <= 1'b0;
            bus.s_we     <= 1'b0;
            bus.s_addr   <= '0;
            bus.s_wdata  <= '0;
            bus.m0_ack   <= 1'b0;
            bus.m0_err   <= 1'b0;
            bus.m0_rdata <= '0;
            bus.m1_ack   <= 1'b0;
            bus.m1_err   <= 1'b0;
            bus.m1_rdata <= '0;
        end else begin
            bus.m0_ack <= 1'b0;
            bus.m1_ack <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (grant_m0) begin
                        bus.s_req   <= 1'b1;
                        bus.s_we    <= bus.m0_we;
                        bus.s_addr  <= bus.m0_addr;
                        bus.s_wdata <= bus.m0_wdata;
                        state       <= ARB_BUSY_M0;
                    end else if (grant_m1) begin
                        bus.s_req   <= 1'b1;
                        bus.s_we    <= bus.m1_we;
                        bus.s_addr  <= bus.m1_addr;
                        bus.s_wdata <= bus.m1_wdata;
                        state       <= ARB_BUSY_M1;
                    end
                end
                ARB_BUSY_M0: begin
                    if (bus.s_ack) begin
                        bus.m0_rdata <= bus.s_rdata;
                        bus.m0_ack   <= 1'b1;
                        bus.m0_err   <= 1'b0;
                        bus.s_req    <= 1'b0;
                        state        <= ARB_IDLE;
                    end else if (wd_expire) begin
                        bus.m0_rdata <= '0;
                        bus.m0_ack   <= 1'b1;
                        bus.m0_err   <= 1'b1;
                        bus.s_req    <= 1'b0;
                        state        <= ARB_IDLE;
                    end
                end
                ARB_BUSY_M1: begin
                    if (bus.s_ack) begin
                        bus.m1_rdata <= bus.s_rdata;
                        bus.m1_ack   <= 1'b1;
                        bus.m1_err   <= 1'b0;
                        bus.s_req    <= 1'b0;
                        state        <= ARB_IDLE;
                    end else if (wd_expire) begin
                        bus.m1_rdata <= '0;
                        bus.m1_ack   <= 1'b1;
                        bus.m1_err   <= 1'b1;
                        bus.s_req    <= 1'b0;
                        state        <= ARB_IDLE;
                    end
                end
                default: begin
                    bus.s_req <= 1'b0;
                    state     <= ARB_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter; the starvation scenario follows ARB_STARVE_GUARD_EN.
module tb_mem_bus_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_bus_arbiter #(
        .AW (32), .DW (32), .TIMEOUT (16), .MAX_CONSEC (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = '0; bus.m0_wdata = '0;
        bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = '0; bus.m1_wdata = '0;
        bus.s_ack = 0; bus.s_rdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        tick(); tick();
        rst = 0;
        checks++;
        if (bus.s_req !== 1'b0 || bus.s_we !== 1'b0 || bus.s_addr !== 32'h0 || bus.s_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_slave: req=%0b we=%0b addr=%h wdata=%h, want all 0", bus.s_req, bus.s_we, bus.s_addr, bus.s_wdata);
        end
        checks++;
        if (bus.m0_ack !== 1'b0 || bus.m1_ack !== 1'b0 || bus.m0_err !== 1'b0 || bus.m1_err !== 1'b0 ||
            bus.m0_rdata !== 32'h0 || bus.m1_rdata !== 32'h0 || bus.hold_flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_masters: acks=%0b%0b errs=%0b%0b rd0=%h rd1=%h hold=%0b, want all 0",
                     bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err, bus.m0_rdata, bus.m1_rdata, bus.hold_flag);
        end
    endtask

    task automatic test_m1_read();
        bus.m1_req = 1; bus.m1_we = 0; bus.m1_addr = 32'h0000_0010;
        tick();
        checks++;
        if (bus.s_req !== 1'b1 || bus.s_addr !== 32'h10 || bus.s_we !== 1'b0 || bus.hold_flag !== 1'b1) begin
            errors++;
            $display("FAIL m1_grant: req=%0b addr=%h we=%0b hold=%0b, want 1 00000010 0 1", bus.s_req, bus.s_addr, bus.s_we, bus.hold_flag);
        end
        tick();
        checks++;
        if (bus.m1_ack !== 1'b0 || bus.s_req !== 1'b1) begin
            errors++;
            $display("FAIL m1_wait: ack=%0b s_req=%0b, want 0 1", bus.m1_ack, bus.s_req);
        end
        bus.s_ack = 1; bus.s_rdata = 32'h0010_0093;
        #1;
        checks++;
        if (bus.hold_flag !== 1'b0) begin
            errors++;
            $display("FAIL m1_hold_release: hold=%0b, want 0", bus.hold_flag);
        end
        tick();
        bus.s_ack = 0;
        checks++;
        if (bus.m1_ack !== 1'b1 || bus.m1_rdata !== 32'h0010_0093 || bus.m1_err !== 1'b0 || bus.s_req !== 1'b0) begin
            errors++;
            $display("FAIL m1_done: ack=%0b rdata=%h err=%0b s_req=%0b, want 1 00100093 0 0", bus.m1_ack, bus.m1_rdata, bus.m1_err, bus.s_req);
        end
        bus.m1_req = 0;
        tick();
        checks++;
        if (bus.m1_ack !== 1'b0 || bus.m1_rdata !== 32'h0010_0093) begin
            errors++;
            $display("FAIL m1_ack_pulse: ack=%0b rdata=%h, want 0 00100093", bus.m1_ack, bus.m1_rdata);
        end
    endtask

    task automatic test_priority();
        bus.m0_req = 1; bus.m0_we = 1; bus.m0_addr = 32'h100; bus.m0_wdata = 32'hDEAD_BEEF;
        bus.m1_req = 1; bus.m1_we = 0; bus.m1_addr = 32'h200;
        tick();
        checks++;
        if (bus.s_req !== 1'b1 || bus.s_we !== 1'b1 || bus.s_addr !== 32'h100 || bus.s_wdata !== 32'hDEAD_BEEF || bus.hold_flag !== 1'b1) begin
            errors++;
            $display("FAIL prio_m0_first: req=%0b we=%0b addr=%h wdata=%h hold=%0b, want 1 1 00000100 deadbeef 1",
                     bus.s_req, bus.s_we, bus.s_addr, bus.s_wdata, bus.hold_flag);
        end
        bus.s_ack = 1; bus.s_rdata = 32'hAAAA_5555;
        tick();
        bus.s_ack = 0;
        checks++;
        if (bus.m0_ack !== 1'b1 || bus.m0_err !== 1'b0 || bus.m1_ack !== 1'b0 || bus.s_req !== 1'b0 || bus.hold_flag !== 1'b1) begin
            errors++;
            $display("FAIL prio_m0_done: m0_ack=%0b err=%0b m1_ack=%0b s_req=%0b hold=%0b, want 1 0 0 0 1",
                     bus.m0_ack, bus.m0_err, bus.m1_ack, bus.s_req, bus.hold_flag);
        end
        bus.m0_req = 0;
        tick();
        checks++;
        if (bus.s_req !== 1'b1 || bus.s_we !== 1'b0 || bus.s_addr !== 32'h200 || bus.hold_flag !== 1'b1 || bus.m0_ack !== 1'b0) begin
            errors++;
            $display("FAIL prio_m1_second: req=%0b we=%0b addr=%h hold=%0b m0_ack=%0b, want 1 0 00000200 1 0",
                     bus.s_req, bus.s_we, bus.s_addr, bus.hold_flag, bus.m0_ack);
        end
        bus.s_ack = 1; bus.s_rdata = 32'h1234_5678;
        tick();
        bus.s_ack = 0;
        checks++;
        if (bus.m1_ack !== 1'b1 || bus.m1_rdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL prio_m1_done: ack=%0b rdata=%h, want 1 12345678", bus.m1_ack, bus.m1_rdata);
        end
        bus.m1_req = 0;
        tick();
    endtask

    task automatic test_timeout();
        int early;
        // Slave silent: abort lands exactly 16 cycles after s_req rose
        bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 32'h300;
        tick();
        early = 0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (bus.m0_ack !== 1'b0 || bus.s_req !== 1'b1) early++;
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL timeout_early: %0d cycles with ack or dropped s_req, want 0", early);
        end
        tick();
        checks++;
        if (bus.m0_ack !== 1'b1 || bus.m0_err !== 1'b1 || bus.m0_rdata !== 32'h0 || bus.s_req !== 1'b0) begin
            errors++;
            $display("FAIL timeout_abort: ack=%0b err=%0b rdata=%h s_req=%0b, want 1 1 00000000 0",
                     bus.m0_ack, bus.m0_err, bus.m0_rdata, bus.s_req);
        end
        bus.m0_req = 0;
        tick();
        checks++;
        if (bus.m0_ack !== 1'b0 || bus.s_req !== 1'b0) begin
            errors++;
            $display("FAIL timeout_after: ack=%0b s_req=%0b, want 0 0", bus.m0_ack, bus.s_req);
        end
        // s_ack arriving on the expiry cycle wins
        bus.m0_req = 1;
        tick();
        for (int k = 1; k <= 15; k++) tick();
        bus.s_ack = 1; bus.s_rdata = 32'hCAFE_F00D;
        tick();
        bus.s_ack = 0;
        checks++;
        if (bus.m0_ack !== 1'b1 || bus.m0_err !== 1'b0 || bus.m0_rdata !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL timeout_race: ack=%0b err=%0b rdata=%h, want 1 0 cafef00d", bus.m0_ack, bus.m0_err, bus.m0_rdata);
        end
        bus.m0_req = 0;
        tick();
    endtask

    task automatic test_reset_mid();
        bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 32'h400;
        tick();
        checks++;
        if (bus.s_req !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_grant: s_req=%0b, want 1", bus.s_req);
        end
        rst = 1;
        tick();
        rst = 0; bus.m0_req = 0;
        checks++;
        if (bus.s_req !== 1'b0 || bus.m0_ack !== 1'b0 || bus.s_addr !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_abort: s_req=%0b m0_ack=%0b addr=%h, want 0 0 00000000", bus.s_req, bus.m0_ack, bus.s_addr);
        end
        bus.m1_req = 1; bus.m1_we = 0; bus.m1_addr = 32'h40;
        tick();
        checks++;
        if (bus.m0_ack !== 1'b0 || bus.s_req !== 1'b1 || bus.s_addr !== 32'h40) begin
            errors++;
            $display("FAIL rstmid_next_grant: m0_ack=%0b s_req=%0b addr=%h, want 0 1 00000040", bus.m0_ack, bus.s_req, bus.s_addr);
        end
        bus.s_ack = 1; bus.s_rdata = 32'h0BAD_C0DE;
        tick();
        bus.s_ack = 0;
        checks++;
        if (bus.m1_ack !== 1'b1 || bus.m1_rdata !== 32'h0BAD_C0DE || bus.m1_err !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_next_done: ack=%0b rdata=%h err=%0b, want 1 0badc0de 0", bus.m1_ack, bus.m1_rdata, bus.m1_err);
        end
        bus.m1_req = 0;
        tick();
    endtask

    task automatic test_starve();
        logic exp_grant [6];
        logic got_grant [6];
        int   ng;
`ifdef ARB_STARVE_GUARD_EN
        exp_grant = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`else
        exp_grant = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        got_grant = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        ng = 0;
        bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 32'hA00;
        bus.m1_req = 1; bus.m1_we = 0; bus.m1_addr = 32'hB00;
        for (int c = 0; c < 40 && ng < 6; c++) begin
            tick();
            if (bus.s_req === 1'b1 && bus.s_ack === 1'b0) begin
                got_grant[ng] = (bus.s_addr == 32'hB00);
                ng++;
                bus.s_ack = 1;
            end else begin
                bus.s_ack = 0;
            end
        end
        checks++;
        if (ng != 6) begin
            errors++;
            $display("FAIL starve_count: saw %0d grants in budget, want 6", ng);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got_grant[i] !== exp_grant[i]) begin
                errors++;
                $display("FAIL starve_grant%0d: master=%0d, want %0d", i, got_grant[i], exp_grant[i]);
            end
        end
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
        tick();
    endtask

    task automatic test_stray_and_drop();
        bus.s_ack = 1; bus.s_rdata = 32'hFFFF_FFFF;
        tick();
        bus.s_ack = 0;
        checks++;
        if (bus.m0_ack !== 1'b0 || bus.m1_ack !== 1'b0 || bus.s_req !== 1'b0 || bus.m0_rdata !== 32'h0) begin
            errors++;
            $display("FAIL stray_ack: m0_ack=%0b m1_ack=%0b s_req=%0b rd0=%h, want 0 0 0 00000000",
                     bus.m0_ack, bus.m1_ack, bus.s_req, bus.m0_rdata);
        end
        bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 32'h500;
        tick();
        bus.m0_req = 0;
        tick();
        checks++;
        if (bus.s_req !== 1'b1 || bus.s_addr !== 32'h500 || bus.m0_ack !== 1'b0) begin
            errors++;
            $display("FAIL drop_held: s_req=%0b addr=%h ack=%0b, want 1 00000500 0", bus.s_req, bus.s_addr, bus.m0_ack);
        end
        bus.s_ack = 1; bus.s_rdata = 32'h0000_5A5A;
        tick();
        bus.s_ack = 0;
        checks++;
        if (bus.m0_ack !== 1'b1 || bus.m0_rdata !== 32'h0000_5A5A || bus.s_req !== 1'b0) begin
            errors++;
            $display("FAIL drop_done: ack=%0b rdata=%h s_req=%0b, want 1 00005a5a 0", bus.m0_ack, bus.m0_rdata, bus.s_req);
        end
        tick();
        checks++;
        if (bus.m0_ack !== 1'b0 || bus.s_req !== 1'b0) begin
            errors++;
            $display("FAIL drop_idle: ack=%0b s_req=%0b, want 0 0", bus.m0_ack, bus.s_req);
        end
    endtask

    initial begin
        test_reset();
        test_m1_read();
        test_priority();
        test_timeout();
        test_reset_mid();
        test_starve();
        test_stray_and_drop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
